// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - button/switch inputs, counter readback and control outputs of counter_ctrl
interface counter_ctrl_if;
    logic       counter_ctrl_start;
    logic       counter_ctrl_stop;
    logic       counter_ctrl_clear;
    logic       counter_ctrl_mode;
    logic [3:0] counter_ctrl_limit_tens;
    logic [3:0] counter_ctrl_limit_ones;
    logic [3:0] counter_ctrl_first_num;
    logic [3:0] counter_ctrl_second_num;
    logic       counter_ctrl_cnt_en;
    logic       counter_ctrl_cnt_clr;
    logic       counter_ctrl_done;
    logic [1:0] counter_ctrl_state;

    // Board side: drives buttons, switches and counter readback.
    modport master (
        output counter_ctrl_start, counter_ctrl_stop, counter_ctrl_clear, counter_ctrl_mode,
        output counter_ctrl_limit_tens, counter_ctrl_limit_ones,
        output counter_ctrl_first_num, counter_ctrl_second_num,
        input  counter_ctrl_cnt_en, counter_ctrl_cnt_clr, counter_ctrl_done, counter_ctrl_state
    );

    modport slave (
        input  counter_ctrl_start, counter_ctrl_stop, counter_ctrl_clear, counter_ctrl_mode,
        input  counter_ctrl_limit_tens, counter_ctrl_limit_ones,
        input  counter_ctrl_first_num, counter_ctrl_second_num,
        output counter_ctrl_cnt_en, counter_ctrl_cnt_clr, counter_ctrl_done, counter_ctrl_state
    );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run/pause/clear FSM, tick prescaler and limit stop for the two-digit BCD counter
module counter_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic           counter_ctrl_clk,
    input  logic           counter_ctrl_rst,
    counter_ctrl_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } stateT;

    stateT         stateQ;
    logic [PW-1:0] prescQ;
    logic          cntEnQ;
    logic          cntClrQ;
    logic          doneQ;
    logic          modeQ;
    logic [3:0]    limTensQ;
    logic [3:0]    limOnesQ;
    logic          startQ;
    logic          stopQ;
    logic          clearQ;

    logic startEdge;
    logic stopEdge;
    logic clearEdge;
    logic limitHit;

    assign startEdge = bus.counter_ctrl_start & ~startQ;
    assign stopEdge  = bus.counter_ctrl_stop  & ~stopQ;
    assign clearEdge = bus.counter_ctrl_clear & ~clearQ;

    // Digits >9 in the latched limit can never equal a real counter value.
    assign limitHit = modeQ &&
                      ({bus.counter_ctrl_second_num, bus.counter_ctrl_first_num} == {limTensQ, limOnesQ});

    always_ff @(posedge counter_ctrl_clk) begin
        if (counter_ctrl_rst) begin
            stateQ   <= IDLE;
            prescQ   <= '0;
            cntEnQ   <= 1'b0;
            cntClrQ  <= 1'b0;
            doneQ    <= 1'b0;
            modeQ    <= 1'b0;
            limTensQ <= 4'd0;
            limOnesQ <= 4'd0;
            // History starts high so a button held through reset gives no edge.
            startQ   <= 1'b1;
            stopQ    <= 1'b1;
            clearQ   <= 1'b1;
        end else begin
            startQ  <= bus.counter_ctrl_start;
            stopQ   <= bus.counter_ctrl_stop;
            clearQ  <= bus.counter_ctrl_clear;
            cntEnQ  <= 1'b0;
            cntClrQ <= 1'b0;

            if (clearEdge) begin
                stateQ  <= IDLE;
                prescQ  <= '0;
                doneQ   <= 1'b0;
                cntClrQ <= 1'b1;
            end else begin
                case (stateQ)
                    IDLE: begin
                        if (startEdge) begin
                            stateQ   <= RUN;
                            prescQ   <= '0;
                            modeQ    <= bus.counter_ctrl_mode;
                            limTensQ <= bus.counter_ctrl_limit_tens;
                            limOnesQ <= bus.counter_ctrl_limit_ones;
                        end
                    end
                    RUN: begin
                        // Limit beats stop; a tick due in the same cycle is dropped.
                        if (limitHit) begin
                            stateQ <= DONE;
                            doneQ  <= 1'b1;
                        end else if (stopEdge) begin
                            stateQ <= PAUSE;
                        end else if (prescQ == PRESC_MAX) begin
                            prescQ <= '0;
                            cntEnQ <= 1'b1;
                        end else begin
                            prescQ <= prescQ + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (startEdge) begin
                            stateQ <= RUN;
                        end
                    end
                    DONE: begin
                        doneQ <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.counter_ctrl_cnt_en  = cntEnQ;
    assign bus.counter_ctrl_cnt_clr = cntClrQ;
    assign bus.counter_ctrl_done    = doneQ;
    assign bus.counter_ctrl_state   = stateQ;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed bench for counter_ctrl with a BCD counter model on the readback
module tb_counter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_ctrl_if bus ();

    counter_ctrl #(.TICK_DIV(4)) dut (
        .counter_ctrl_clk (clk),
        .counter_ctrl_rst (rst),
        .bus              (bus)
    );

    int total = 0;
    int bad = 0;
    int enCnt = 0;
    int snap = 0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic incPend = 1'b0;
    logic clrPend = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; the counter model applies last cycle's enable/clear just as the real counter would.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (clrPend) begin
            ones = 4'd0;
            tens = 4'd0;
        end else if (incPend) begin
            if (ones == 4'd9) begin
                ones = 4'd0;
                tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                ones = ones + 4'd1;
            end
        end
        bus.counter_ctrl_first_num  = ones;
        bus.counter_ctrl_second_num = tens;
        clrPend = bus.counter_ctrl_cnt_clr;
        incPend = bus.counter_ctrl_cnt_en;
        if (bus.counter_ctrl_cnt_en) enCnt++;
    endtask

    task automatic cycN(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bus.counter_ctrl_start = 1'b1;
        bus.counter_ctrl_stop = 1'b0;
        bus.counter_ctrl_clear = 1'b0;
        bus.counter_ctrl_mode = 1'b0;
        bus.counter_ctrl_limit_tens = 4'd0;
        bus.counter_ctrl_limit_ones = 4'd0;
        bus.counter_ctrl_first_num = 4'd0;
        bus.counter_ctrl_second_num = 4'd0;

        // Reset with start held
        cycN(2);
        rst = 1'b0;
        cyc();
        check("rst_state", int'(bus.counter_ctrl_state), 0);
        check("rst_cnt_en", int'(bus.counter_ctrl_cnt_en), 0);
        check("rst_cnt_clr", int'(bus.counter_ctrl_cnt_clr), 0);
        check("rst_done", int'(bus.counter_ctrl_done), 0);
        cycN(3);
        check("held_start_idle", int'(bus.counter_ctrl_state), 0);
        bus.counter_ctrl_start = 1'b0;
        cyc();

        // Free run, tick cadence
        enCnt = 0;
        bus.counter_ctrl_start = 1'b1;
        cyc();
        check("start_run", int'(bus.counter_ctrl_state), 1);
        bus.counter_ctrl_start = 1'b0;
        cycN(3);
        check("no_early_tick", enCnt, 0);
        cyc();
        check("first_tick", int'(bus.counter_ctrl_cnt_en), 1);
        cycN(36);
        check("tenth_tick", int'(bus.counter_ctrl_cnt_en), 1);
        check("ten_ticks", enCnt, 10);

        // Pause two cycles after a tick, then resume
        cycN(2);
        bus.counter_ctrl_stop = 1'b1;
        cyc();
        check("pause_state", int'(bus.counter_ctrl_state), 2);
        bus.counter_ctrl_stop = 1'b0;
        snap = enCnt;
        cycN(20);
        check("pause_no_tick", enCnt, snap);
        check("pause_hold", int'(bus.counter_ctrl_state), 2);
        bus.counter_ctrl_start = 1'b1;
        cyc();
        check("resume_run", int'(bus.counter_ctrl_state), 1);
        bus.counter_ctrl_start = 1'b0;
        cyc();
        check("resume_gap", int'(bus.counter_ctrl_cnt_en), 0);
        cyc();
        check("resume_tick", int'(bus.counter_ctrl_cnt_en), 1);

        // Clear and stop together in RUN
        bus.counter_ctrl_clear = 1'b1;
        bus.counter_ctrl_stop = 1'b1;
        cyc();
        check("clr_state", int'(bus.counter_ctrl_state), 0);
        check("clr_pulse", int'(bus.counter_ctrl_cnt_clr), 1);
        check("clr_no_en", int'(bus.counter_ctrl_cnt_en), 0);
        bus.counter_ctrl_clear = 1'b0;
        bus.counter_ctrl_stop = 1'b0;
        cyc();
        check("clr_one_cycle", int'(bus.counter_ctrl_cnt_clr), 0);

        // Limit 12, then change limit inputs mid-run
        bus.counter_ctrl_mode = 1'b1;
        bus.counter_ctrl_limit_tens = 4'd1;
        bus.counter_ctrl_limit_ones = 4'd2;
        enCnt = 0;
        bus.counter_ctrl_start = 1'b1;
        cyc();
        check("lim_run", int'(bus.counter_ctrl_state), 1);
        bus.counter_ctrl_start = 1'b0;
        bus.counter_ctrl_limit_tens = 4'd0;
        bus.counter_ctrl_limit_ones = 4'd5;
        cycN(3);
        check("restart_presc", enCnt, 0);
        cyc();
        check("restart_tick", int'(bus.counter_ctrl_cnt_en), 1);
        for (int i = 0; i < 200 && enCnt < 12; i++) cyc();
        check("lim_twelve_ticks", enCnt, 12);
        check("lim_still_run", int'(bus.counter_ctrl_state), 1);
        cyc();
        check("lim_compare_cycle", int'(bus.counter_ctrl_state), 1);
        check("lim_no_extra_en", int'(bus.counter_ctrl_cnt_en), 0);
        cyc();
        check("lim_done_state", int'(bus.counter_ctrl_state), 3);
        check("lim_done_flag", int'(bus.counter_ctrl_done), 1);
        cycN(10);
        check("done_no_tick", enCnt, 12);
        bus.counter_ctrl_start = 1'b1;
        cyc();
        bus.counter_ctrl_start = 1'b0;
        bus.counter_ctrl_stop = 1'b1;
        cyc();
        bus.counter_ctrl_stop = 1'b0;
        cyc();
        check("done_sticky", int'(bus.counter_ctrl_state), 3);

        // Start with digits already at the limit
        bus.counter_ctrl_clear = 1'b1;
        cyc();
        check("clr_from_done", int'(bus.counter_ctrl_state), 0);
        check("clr_done_low", int'(bus.counter_ctrl_done), 0);
        bus.counter_ctrl_clear = 1'b0;
        cyc();
        bus.counter_ctrl_limit_tens = 4'd0;
        bus.counter_ctrl_limit_ones = 4'd0;
        snap = enCnt;
        bus.counter_ctrl_start = 1'b1;
        cyc();
        check("imm_run", int'(bus.counter_ctrl_state), 1);
        bus.counter_ctrl_start = 1'b0;
        cyc();
        check("imm_done", int'(bus.counter_ctrl_state), 3);
        check("imm_no_en", enCnt, snap);

        // Reset in RUN on the cycle a tick would be registered
        bus.counter_ctrl_clear = 1'b1;
        cyc();
        bus.counter_ctrl_clear = 1'b0;
        cyc();
        bus.counter_ctrl_mode = 1'b0;
        bus.counter_ctrl_start = 1'b1;
        cyc();
        check("rr_run", int'(bus.counter_ctrl_state), 1);
        bus.counter_ctrl_start = 1'b0;
        cycN(3);
        rst = 1'b1;
        cyc();
        check("rr_state", int'(bus.counter_ctrl_state), 0);
        check("rr_cnt_en", int'(bus.counter_ctrl_cnt_en), 0);
        check("rr_cnt_clr", int'(bus.counter_ctrl_cnt_clr), 0);
        check("rr_done", int'(bus.counter_ctrl_done), 0);
        rst = 1'b0;
        cycN(5);
        check("rr_idle_after", int'(bus.counter_ctrl_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
